// File: rtl/seq_shift_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_engine_if
//  Purpose  : Command/data bundle between a controller and seq_shift_engine.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic [WIDTH-1:0] data_i;
    logic [2:0]       S_i;
    logic [AMT_W-1:0] amt_i;
    logic             start_i;
    logic             data_L;
    logic             data_R;
    logic [WIDTH-1:0] Y_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output data_i, S_i, amt_i, start_i, data_L, data_R,
        input  Y_o, busy_o, done_o
    );

    modport slave (
        input  data_i, S_i, amt_i, start_i, data_L, data_R,
        output Y_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/seq_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_engine
//  Purpose  : Counted one-bit-per-clock shift/ASR/rotate engine with parallel
//             load and busy/done handshake. Rotates need SEQ_SHIFT_ROTATE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_engine #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic               Clk,
    input  logic               Rst_N,
    seq_shift_engine_if.slave  bus
);

    localparam logic [2:0] c_OP_HOLD = 3'b000;
    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_SHL  = 3'b010;
    localparam logic [2:0] c_OP_SHR  = 3'b011;
    localparam logic [2:0] c_OP_ASR  = 3'b100;
`ifdef SEQ_SHIFT_ROTATE_EN
    localparam logic [2:0] c_OP_ROL  = 3'b101;
    localparam logic [2:0] c_OP_ROR  = 3'b110;
`endif

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [AMT_W-1:0] r_rem,   w_rem_nxt;
    logic [2:0]       r_op,    w_op_nxt;
    logic [WIDTH-1:0] r_y,     w_y_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;

    logic [2:0]       w_op;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_step;

    // In IDLE the live opcode drives the first step; in SHIFT the latched one.
    always_comb begin
        w_op       = (r_state == S_IDLE) ? bus.S_i : r_op;
        w_is_shift = 1'b0;
        w_step     = r_y;
        case (w_op)
            c_OP_SHL: begin
                w_is_shift = 1'b1;
                w_step     = {r_y[WIDTH-2:0], bus.data_R};
            end
            c_OP_SHR: begin
                w_is_shift = 1'b1;
                w_step     = {bus.data_L, r_y[WIDTH-1:1]};
            end
            c_OP_ASR: begin
                w_is_shift = 1'b1;
                w_step     = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
            end
`ifdef SEQ_SHIFT_ROTATE_EN
            c_OP_ROL: begin
                w_is_shift = 1'b1;
                w_step     = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
            end
            c_OP_ROR: begin
                w_is_shift = 1'b1;
                w_step     = {r_y[0], r_y[WIDTH-1:1]};
            end
`endif
            default: begin
                w_is_shift = 1'b0;
                w_step     = r_y;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_y_nxt     = r_y;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    if (w_is_shift && (bus.amt_i != '0)) begin
                        w_y_nxt = w_step;
                        if (bus.amt_i == AMT_W'(1)) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_rem_nxt   = bus.amt_i - AMT_W'(1);
                            w_op_nxt    = bus.S_i;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = S_SHIFT;
                        end
                    end else begin
                        if (bus.S_i == c_OP_LOAD) begin
                            w_y_nxt = bus.data_i;
                        end
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                w_y_nxt   = w_step;
                w_rem_nxt = r_rem - AMT_W'(1);
                if (r_rem == AMT_W'(1)) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_op    <= c_OP_HOLD;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.Y_o    = r_y;
    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_engine
//  Purpose  : Directed plus random command bench for seq_shift_engine with an
//             arithmetic reference model (honours SEQ_SHIFT_ROTATE_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_shift_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    logic Clk   = 1'b0;
    logic Rst_N = 1'b0;

    seq_shift_engine_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    seq_shift_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .Clk   (Clk),
        .Rst_N (Rst_N),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] y_model  = 8'h00;

`ifdef SEQ_SHIFT_ROTATE_EN
    localparam bit c_ROT = 1'b1;
`else
    localparam bit c_ROT = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_shift_op(input logic [2:0] op);
        return (op == 3'd2) || (op == 3'd3) || (op == 3'd4) ||
               (c_ROT && ((op == 3'd5) || (op == 3'd6)));
    endfunction

    // Result of a whole command computed in one go from its shift count.
    function automatic logic [7:0] model(input logic [7:0] y, input logic [2:0] op,
                                         input int n, input logic fl, input logic fr,
                                         input logic [7:0] d);
        logic [31:0]        mask;
        logic [31:0]        t;
        logic signed [7:0]  sy;
        logic [15:0]        dbl;
        int                 k;
        mask = (n >= 8) ? 32'hFF : ((32'd1 << n) - 32'd1);
        if (op == 3'd1) return d;
        if (!is_shift_op(op)) return y;
        case (op)
            3'd2: begin
                if (n >= 8) return {8{fr}};
                t = (32'(y) << n) | (fr ? mask : 32'd0);
                return t[7:0];
            end
            3'd3: begin
                if (n >= 8) return {8{fl}};
                t = (32'(y) >> n) | (fl ? (mask << (8 - n)) : 32'd0);
                return t[7:0];
            end
            3'd4: begin
                sy = y;
                return 8'(sy >>> n);
            end
            3'd5: begin
                k   = n % 8;
                dbl = {y, y} << k;
                return dbl[15:8];
            end
            default: begin
                k   = n % 8;
                dbl = {y, y} >> k;
                return dbl[7:0];
            end
        endcase
    endfunction

    function automatic int lat_model(input logic [2:0] op, input int n);
        return (is_shift_op(op) && n >= 2) ? n - 1 : 0;
    endfunction

    task automatic run_cmd(input string tag, input logic [2:0] op, input int n,
                           input logic [7:0] d, input logic fl, input logic fr,
                           input bit noise);
        logic [7:0] exp_y;
        int         exp_lat;
        int         lat;
        exp_y   = model(y_model, op, n, fl, fr, d);
        exp_lat = lat_model(op, n);
        @(negedge Clk);
        bus.S_i     = op;
        bus.amt_i   = 4'(n);
        bus.data_i  = d;
        bus.data_L  = fl;
        bus.data_R  = fr;
        bus.start_i = 1'b1;
        @(posedge Clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            chk({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
            // Junk LOAD commands while busy must be ignored entirely.
            if (noise) begin
                bus.start_i = 1'b1;
                bus.S_i     = 3'b001;
                bus.data_i  = 8'($urandom);
                bus.amt_i   = 4'($urandom);
            end
            @(posedge Clk);
            #1;
            bus.start_i = 1'b0;
            lat++;
        end
        chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
        chk({tag, "_y"},    32'(bus.Y_o), 32'(exp_y));
        chk({tag, "_bsy0"}, 32'(bus.busy_o), 32'd0);
        y_model = exp_y;
    endtask

    initial begin
        bus.data_i  = '0;
        bus.S_i     = '0;
        bus.amt_i   = '0;
        bus.start_i = 1'b0;
        bus.data_L  = 1'b0;
        bus.data_R  = 1'b0;

        #12;
        chk("rst_y",    32'(bus.Y_o),    32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        @(negedge Clk);
        Rst_N = 1'b1;

        run_cmd("load_a5", 3'd1, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
        run_cmd("load_81", 3'd1, 0, 8'h81, 1'b0, 1'b0, 1'b0);
        run_cmd("shl3",    3'd2, 3, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("shl3_val", 32'(y_model), 32'h0F);
        run_cmd("load_90", 3'd1, 0, 8'h90, 1'b0, 1'b0, 1'b0);
        run_cmd("asr2",    3'd4, 2, 8'h00, 1'b1, 1'b1, 1'b0);
        run_cmd("load_90b",3'd1, 0, 8'h90, 1'b0, 1'b0, 1'b0);
        run_cmd("shr2",    3'd3, 2, 8'h00, 1'b0, 1'b1, 1'b0);
        run_cmd("load_81b",3'd1, 0, 8'h81, 1'b0, 1'b0, 1'b0);
        run_cmd("rol9",    3'd5, 9, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd("load_3c", 3'd1, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
        run_cmd("shr4_ign",3'd3, 4, 8'h00, 1'b1, 1'b0, 1'b1);
        run_cmd("shl15",   3'd2, 15, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd("load_c3", 3'd1, 0, 8'hC3, 1'b0, 1'b0, 1'b0);
        run_cmd("asr15",   3'd4, 15, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd("load_5a", 3'd1, 0, 8'h5A, 1'b0, 1'b0, 1'b0);
        run_cmd("ror8",    3'd6, 8, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd("ror3",    3'd6, 3, 8'h00, 1'b0, 1'b0, 1'b0);
        run_cmd("shl0",    3'd2, 0, 8'h00, 1'b0, 1'b1, 1'b0);
        run_cmd("shr1",    3'd3, 1, 8'h00, 1'b1, 1'b0, 1'b0);
        run_cmd("hold",    3'd0, 7, 8'hFF, 1'b1, 1'b1, 1'b0);
        run_cmd("rsvd",    3'd7, 7, 8'hFF, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_cmd("rnd", 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge Clk);
                #1;
                chk("rnd_pulse", 32'(bus.done_o), 32'd0);
            end
        end

        // Asynchronous reset while a shift still has two steps left.
        run_cmd("pre_rst", 3'd1, 0, 8'hF0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        bus.S_i     = 3'd2;
        bus.amt_i   = 4'd5;
        bus.data_R  = 1'b1;
        bus.start_i = 1'b1;
        @(posedge Clk);
        #1;
        bus.start_i = 1'b0;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        chk("mid_busy", 32'(bus.busy_o), 32'd1);
        #2;
        Rst_N = 1'b0;
        #1;
        chk("mid_rst_y",    32'(bus.Y_o),    32'd0);
        chk("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        chk("mid_rst_done", 32'(bus.done_o), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            chk("post_rst_done", 32'(bus.done_o), 32'd0);
            chk("post_rst_busy", 32'(bus.busy_o), 32'd0);
        end
        y_model = 8'h00;
        run_cmd("post_rst_shr", 3'd3, 3, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
